// File: rtl/console_bus_pkg.sv
// ============================================================================
//  Module      : console_bus_pkg
//  Description : Shared types for the console system bus: address/data
//                widths, bus-owner encoding and the default DMA burst limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package console_bus_pkg;

    // 16-bit system address and 8-bit data bus
    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    // Bus owner in the current cycle; doubles as the arbiter state
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DMA_XFER = 2'd2
    } owner_e;

    // Consecutive DMA grants allowed while the CPU is kept waiting
    localparam int BURST_MAX_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-requester (CPU, sprite/DMA) arbiter for the shared
//                console bus. One transfer per bus cycle, DMA priority with a
//                burst limit that protects CPU latency, registered bus
//                outputs and one-cycle-late read-data return per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import console_bus_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    // CPU requester
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,

    // Sprite/DMA requester
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_rw,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,

    // Shared bus towards the external address decoder
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_wdata,
    output logic        bus_valid,
    input  logic [7:0]  bus_rdata
);

    // Streak counter must be able to hold 0..BURST_MAX inclusive
    localparam int                  STREAK_W   = $clog2(BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(BURST_MAX);

    owner_e              state_q,      state_d;
    logic [STREAK_W-1:0] dma_streak_q, dma_streak_d;

    logic                cpu_gnt_q,    cpu_gnt_d;
    logic                dma_gnt_q,    dma_gnt_d;
    logic                bus_valid_q,  bus_valid_d;
    addr_t               bus_addr_q,   bus_addr_d;
    logic                bus_rw_q,     bus_rw_d;
    data_t               bus_wdata_q,  bus_wdata_d;

    logic                cpu_rvalid_q, cpu_rvalid_d;
    data_t               cpu_rdata_q,  cpu_rdata_d;
    logic                dma_rvalid_q, dma_rvalid_d;
    data_t               dma_rdata_q,  dma_rdata_d;

    logic                cpu_elig;
    logic                dma_elig;

    // Pick next cycle's bus owner and maintain the DMA burst streak
    always_comb begin
        // A requester being served this cycle sits out the next decision,
        // which yields the 1-in-2 per-requester rate and CPU/DMA interleave.
        cpu_elig     = cpu_req && !cpu_gnt_q;
        dma_elig     = dma_req && !dma_gnt_q;
        state_d      = IDLE;
        dma_streak_d = dma_streak_q;

        if (cpu_elig && dma_elig) begin
            state_d = (dma_streak_q == STREAK_MAX) ? CPU_XFER : DMA_XFER;
        end else if (cpu_elig) begin
            state_d = CPU_XFER;
        end else if (dma_elig) begin
            state_d = DMA_XFER;
        end

        // Streak counts DMA wins taken while the CPU was asking too
        if (state_d == CPU_XFER) begin
            dma_streak_d = '0;
        end else if ((state_d == DMA_XFER) && cpu_req && (dma_streak_q != STREAK_MAX)) begin
            dma_streak_d = dma_streak_q + 1'b1;
        end
    end

    // Next-cycle bus drive, grants and read-data capture
    always_comb begin
        cpu_gnt_d   = (state_d == CPU_XFER);
        dma_gnt_d   = (state_d == DMA_XFER);
        bus_valid_d = (state_d != IDLE);
        // Idle bus: direction parks at read, address/data keep last values
        bus_addr_d  = bus_addr_q;
        bus_rw_d    = 1'b0;
        bus_wdata_d = bus_wdata_q;

        case (state_d)
            CPU_XFER: begin
                bus_addr_d  = cpu_addr;
                bus_rw_d    = cpu_rw;
                bus_wdata_d = cpu_wdata;
            end
            DMA_XFER: begin
                bus_addr_d  = dma_addr;
                bus_rw_d    = dma_rw;
                bus_wdata_d = dma_wdata;
            end
            default: ;
        endcase

        // Read data is sampled at the close of the owner's bus cycle
        cpu_rvalid_d = cpu_gnt_q && !bus_rw_q;
        dma_rvalid_d = dma_gnt_q && !bus_rw_q;
        cpu_rdata_d  = cpu_rvalid_d ? bus_rdata : cpu_rdata_q;
        dma_rdata_d  = dma_rvalid_d ? bus_rdata : dma_rdata_q;
    end

    // Arbiter state and registered outputs; reset drops any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dma_streak_q <= '0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_rw_q     <= 1'b0;
            bus_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dma_streak_q <= dma_streak_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_rw_q     <= bus_rw_d;
            bus_wdata_q  <= bus_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dma_gnt    = dma_gnt_q;
    assign bus_valid  = bus_valid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_rw     = bus_rw_q;
    assign bus_wdata  = bus_wdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter: directed vectors,
//                hand-written corner sequences and a randomized run against
//                a cycle-level behavioural model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int BM = 4;

    logic        clk, rst_n;
    logic        cpu_req, cpu_rw, dma_req, dma_rw;
    logic [15:0] cpu_addr, dma_addr, bus_addr;
    logic [7:0]  cpu_wdata, dma_wdata, bus_wdata, bus_rdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, bus_rw, bus_valid;
    logic [7:0]  cpu_rdata, dma_rdata;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.BURST_MAX(BM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_rw     (dma_rw),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_wdata  (bus_wdata),
        .bus_valid  (bus_valid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = CPU, 2 = DMA
    int          m_owner, m_streak;
    logic [15:0] m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata, m_crd, m_drd;
    logic        m_crv, m_drv;

    task automatic model_reset();
        m_owner = 0; m_streak = 0; m_addr = '0; m_rw = 1'b0; m_wdata = '0;
        m_crd = '0; m_drd = '0; m_crv = 1'b0; m_drv = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now on the pins
    task automatic model_step();
        bit ce, de;
        int nxt;
        m_crv = (m_owner == 1) && !m_rw;
        m_drv = (m_owner == 2) && !m_rw;
        if (m_crv) m_crd = bus_rdata;
        if (m_drv) m_drd = bus_rdata;
        ce = cpu_req && (m_owner != 1);
        de = dma_req && (m_owner != 2);
        if (ce && de)  nxt = (m_streak == BM) ? 1 : 2;
        else if (ce)   nxt = 1;
        else if (de)   nxt = 2;
        else           nxt = 0;
        if (nxt == 1)                   m_streak = 0;
        else if (nxt == 2 && cpu_req)   m_streak = (m_streak < BM) ? m_streak + 1 : BM;
        if (nxt == 1)      begin m_addr = cpu_addr; m_rw = cpu_rw; m_wdata = cpu_wdata; end
        else if (nxt == 2) begin m_addr = dma_addr; m_rw = dma_rw; m_wdata = dma_wdata; end
        else               m_rw = 1'b0;
        m_owner = nxt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("cpu_gnt",    32'(cpu_gnt),    32'(m_owner == 1));
        chk("dma_gnt",    32'(dma_gnt),    32'(m_owner == 2));
        chk("bus_valid",  32'(bus_valid),  32'(m_owner != 0));
        chk("bus_addr",   32'(bus_addr),   32'(m_addr));
        chk("bus_rw",     32'(bus_rw),     32'(m_rw));
        chk("bus_wdata",  32'(bus_wdata),  32'(m_wdata));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(m_crd));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
        chk("dma_rdata",  32'(dma_rdata),  32'(m_drd));
        chk("gnt_exclusive", 32'(cpu_gnt && dma_gnt), 32'd0);
    endtask

    // One clock: model follows pins, then outputs are compared after the edge
    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic c;    // cpu_req
        logic d;    // dma_req
        logic ec;   // expected cpu_gnt next cycle
        logic ed;   // expected dma_gnt next cycle
    } vec_t;

    vec_t vt [0:19];

    initial begin
        // Both requesting continuously: D,C,D,C,...
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        // DMA wins four contested slots, the fifth goes to the CPU
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0};
        // Streak was cleared by the CPU grant, so DMA wins again
        vt[18] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0};
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_rw = 1'b0; cpu_wdata = '0;
        dma_req = 1'b0; dma_addr = '0; dma_rw = 1'b0; dma_wdata = '0;
        bus_rdata = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_bus_valid", 32'(bus_valid), 32'd0);
        rst_n = 1'b1;

        // CPU read of 0x0123 returning 0x5A
        cpu_req = 1'b1; cpu_addr = 16'h0123; cpu_rw = 1'b0; bus_rdata = 8'h5A;
        run_cycle();
        chk("rd_cpu_gnt",  32'(cpu_gnt),  32'd1);
        chk("rd_bus_addr", 32'(bus_addr), 32'h0123);
        chk("rd_bus_rw",   32'(bus_rw),   32'd0);
        cpu_req = 1'b0;
        run_cycle();
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_cpu_rdata",  32'(cpu_rdata),  32'h5A);
        chk("rd_bus_valid_off", 32'(bus_valid), 32'd0);
        run_cycle();
        chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'd0);
        chk("rd_rdata_hold",   32'(cpu_rdata),  32'h5A);

        // DMA write 0xA5 to 0xF010
        dma_req = 1'b1; dma_addr = 16'hF010; dma_rw = 1'b1; dma_wdata = 8'hA5;
        run_cycle();
        chk("wr_dma_gnt",   32'(dma_gnt),   32'd1);
        chk("wr_bus_valid", 32'(bus_valid), 32'd1);
        chk("wr_bus_rw",    32'(bus_rw),    32'd1);
        chk("wr_bus_wdata", 32'(bus_wdata), 32'hA5);
        chk("wr_bus_addr",  32'(bus_addr),  32'hF010);
        dma_req = 1'b0;
        run_cycle();
        chk("wr_no_rvalid",   32'(dma_rvalid), 32'd0);
        chk("wr_idle_rw",     32'(bus_rw),     32'd0);
        chk("wr_idle_wdata",  32'(bus_wdata),  32'hA5);
        chk("wr_idle_addr",   32'(bus_addr),   32'hF010);
        dma_rw = 1'b0;

        // Table-driven arbitration patterns
        for (int i = 0; i < 20; i++) begin
            cpu_req  = vt[i].c;  dma_req  = vt[i].d;
            cpu_addr = 16'h1000 + 16'(i); dma_addr = 16'h2000 + 16'(i);
            cpu_rw   = 1'b0;     dma_rw   = 1'b0;
            bus_rdata = 8'($urandom);
            run_cycle();
            chk($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vt[i].ec));
            chk($sformatf("vec%0d_dma_gnt", i), 32'(dma_gnt), 32'(vt[i].ed));
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        run_cycle();

        // Reset in the cycle after a CPU read grant
        cpu_req = 1'b1; cpu_addr = 16'h0042; cpu_rw = 1'b0; bus_rdata = 8'h3C;
        run_cycle();
        chk("rst_pre_gnt", 32'(cpu_gnt), 32'd1);
        cpu_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_cpu_gnt",   32'(cpu_gnt),    32'd0);
        chk("rst_async_valid",     32'(bus_valid),  32'd0);
        chk("rst_async_addr",      32'(bus_addr),   32'd0);
        chk("rst_async_rvalid",    32'(cpu_rvalid), 32'd0);
        chk("rst_async_cpu_rdata", 32'(cpu_rdata),  32'd0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        run_cycle();
        chk("rst_no_rvalid", 32'(cpu_rvalid), 32'd0);
        cpu_req = 1'b1; cpu_addr = 16'h0777;
        run_cycle();
        chk("rst_fresh_gnt",  32'(cpu_gnt),  32'd1);
        chk("rst_fresh_addr", 32'(bus_addr), 32'h0777);
        cpu_req = 1'b0;
        run_cycle();

        // Randomized traffic; requests hold their fields until granted
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req || m_owner == 1) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_addr  = 16'($urandom);
                cpu_rw    = 1'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (!dma_req || m_owner == 2) begin
                dma_req   = ($urandom_range(0, 3) != 0);
                dma_addr  = 16'($urandom);
                dma_rw    = 1'($urandom);
                dma_wdata = 8'($urandom);
            end
            bus_rdata = 8'($urandom);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
